// File: rtl/paddle_ctrl_if.sv
// Paddle controller signal bundle.
// master: step/frame/control pulses in, position and status back.
// slave : the paddle controller side.
//   up, down    one-cycle step pulses (toward y=0 / toward y=YMAX)
//   frame_tick  one-cycle pulse at start of vertical blank
//   freeze      level, movement disabled
//   center      one-cycle recentre pulse
//   paddle_y    top edge of paddle (registered)
//   moving      high while steps are being applied
//   move_done   one-cycle pulse when applying finishes
//   at_top      paddle_y == 0
//   at_bottom   paddle_y == YMAX
interface paddle_ctrl_if #(
   parameter int unsigned POS_W = 10
);
   logic             up;
   logic             down;
   logic             frame_tick;
   logic             freeze;
   logic             center;
   logic [POS_W-1:0] paddle_y;
   logic             moving;
   logic             move_done;
   logic             at_top;
   logic             at_bottom;

   modport master (
      output up, down, frame_tick, freeze, center,
      input  paddle_y, moving, move_done, at_top, at_bottom
   );

   modport slave (
      input  up, down, frame_tick, freeze, center,
      output paddle_y, moving, move_done, at_top, at_bottom
   );
endinterface

// File: rtl/paddle_ctrl.sv
// Paddle position controller for one player.
// Accumulates up/down step pulses into a saturating signed pending count and,
// on each frame tick, applies them one STEP per clock, clamped to [0, YMAX].
// Ports:
//   CLK  system clock
//   RST  synchronous active-high reset
//   bus  paddle_ctrl_if.slave (step pulses, frame_tick, freeze, center in;
//        paddle_y, moving, move_done, at_top, at_bottom out)
module paddle_ctrl #(
   parameter int unsigned SCREEN_H = 720,
   parameter int unsigned PADDLE_H = 96,
   parameter int unsigned STEP     = 8,
   parameter int unsigned POS_W    = 10,
   parameter int unsigned PEND_W   = 5
) (
   input logic          CLK,
   input logic          RST,
   paddle_ctrl_if.slave bus
);

   localparam int unsigned YMAX   = SCREEN_H - PADDLE_H;
   localparam int unsigned Y_INIT = YMAX / 2;

   localparam logic [POS_W:0]   StepW  = (POS_W+1)'(STEP);
   localparam logic [POS_W:0]   YmaxW  = (POS_W+1)'(YMAX);
   localparam logic [POS_W-1:0] YmaxP  = POS_W'(YMAX);
   localparam logic [POS_W-1:0] YinitP = POS_W'(Y_INIT);
   localparam logic [POS_W-1:0] StepP  = POS_W'(STEP);

   localparam logic signed [PEND_W:0] SatHi = (PEND_W+1)'((2 ** (PEND_W-1)) - 1);
   localparam logic signed [PEND_W:0] SatLo = -SatHi;

   typedef enum logic [0:0] {StIdle, StApply} state_e;

   state_e             state_q;
   logic [POS_W-1:0]   pos_q;
   logic [PEND_W-1:0]  pending_q;
   logic [PEND_W-1:0]  apply_cnt_q;
   logic               moving_q;
   logic               move_done_q;

   logic signed [PEND_W:0] delta;
   logic signed [PEND_W:0] pend_sum;
   logic [PEND_W-1:0]      pend_sat;
   logic                   dir_up;
   logic [POS_W-1:0]       pos_up;
   logic [POS_W:0]         pos_dn_ext;
   logic [PEND_W-1:0]      cnt_next;

   always_comb begin
      delta = '0;
      if (bus.down && !bus.up) begin
         delta = (PEND_W+1)'(1);
      end else if (bus.up && !bus.down) begin
         delta = '1;
      end

      pend_sum = $signed({pending_q[PEND_W-1], pending_q}) + delta;
      if (pend_sum > SatHi) begin
         pend_sat = SatHi[PEND_W-1:0];
      end else if (pend_sum < SatLo) begin
         pend_sat = SatLo[PEND_W-1:0];
      end else begin
         pend_sat = pend_sum[PEND_W-1:0];
      end

      // Negative apply count means movement toward y=0.
      dir_up     = apply_cnt_q[PEND_W-1];
      pos_up     = pos_q - StepP;
      // One extra bit so the overshoot past YMAX is visible before clamping.
      pos_dn_ext = {1'b0, pos_q} + StepW;
      cnt_next   = dir_up ? apply_cnt_q + PEND_W'(1) : apply_cnt_q - PEND_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= StIdle;
         pos_q       <= YinitP;
         pending_q   <= '0;
         apply_cnt_q <= '0;
         moving_q    <= 1'b0;
         move_done_q <= 1'b0;
      end else if (bus.center) begin
         state_q     <= StIdle;
         pos_q       <= YinitP;
         pending_q   <= '0;
         apply_cnt_q <= '0;
         moving_q    <= 1'b0;
         move_done_q <= 1'b0;
      end else if (bus.freeze) begin
         // Abort any move silently; the position holds where it is.
         state_q     <= StIdle;
         pending_q   <= '0;
         apply_cnt_q <= '0;
         moving_q    <= 1'b0;
         move_done_q <= 1'b0;
      end else begin
         move_done_q <= 1'b0;
         pending_q   <= pend_sat;
         unique case (state_q)
            StIdle: begin
               if (bus.frame_tick && (pending_q != '0)) begin
                  apply_cnt_q <= pending_q;
                  // Restart accumulation with this cycle's pulse so none is lost.
                  pending_q   <= delta[PEND_W-1:0];
                  state_q     <= StApply;
                  moving_q    <= 1'b1;
               end
            end
            StApply: begin
               if (dir_up && ({1'b0, pos_q} < StepW)) begin
                  pos_q       <= '0;
                  apply_cnt_q <= '0;
                  state_q     <= StIdle;
                  moving_q    <= 1'b0;
                  move_done_q <= 1'b1;
               end else if (!dir_up && (pos_dn_ext > YmaxW)) begin
                  pos_q       <= YmaxP;
                  apply_cnt_q <= '0;
                  state_q     <= StIdle;
                  moving_q    <= 1'b0;
                  move_done_q <= 1'b1;
               end else begin
                  pos_q       <= dir_up ? pos_up : pos_dn_ext[POS_W-1:0];
                  apply_cnt_q <= cnt_next;
                  if (cnt_next == '0) begin
                     state_q     <= StIdle;
                     moving_q    <= 1'b0;
                     move_done_q <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign bus.paddle_y  = pos_q;
   assign bus.moving    = moving_q;
   assign bus.move_done = move_done_q;
   assign bus.at_top    = (pos_q == '0);
   assign bus.at_bottom = (pos_q == YmaxP);

endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed testbench for paddle_ctrl: reset, stepping latency, saturation,
// clamping at both ends, simultaneous pulses, freeze, center and reset aborts.
module tb_paddle_ctrl;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   n;

   paddle_ctrl_if #(.POS_W(10)) bus ();

   paddle_ctrl dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step_clk();
      @(posedge CLK);
      #1;
   endtask

   // Present one cycle of pulses, then clear them after the sampling edge.
   task automatic drive(input logic u, input logic d, input logic t, input logic c);
      bus.up         = u;
      bus.down       = d;
      bus.frame_tick = t;
      bus.center     = c;
      step_clk();
      bus.up         = 1'b0;
      bus.down       = 1'b0;
      bus.frame_tick = 1'b0;
      bus.center     = 1'b0;
   endtask

   task automatic pulses(input int num, input logic u, input logic d);
      for (int i = 0; i < num; i++) drive(u, d, 1'b0, 1'b0);
   endtask

   // Cycles after the tick edge until move_done; 0 on timeout.
   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int i = 1; i <= 64; i++) begin
         step_clk();
         if (bus.move_done === 1'b1) begin
            cyc = i;
            break;
         end
      end
      if (cyc == 0) check_val("move_done_timeout", 0, 1);
   endtask

   initial begin
      bus.up = 0; bus.down = 0; bus.frame_tick = 0; bus.freeze = 0; bus.center = 0;

      // Reset
      RST = 1'b1;
      step_clk();
      step_clk();
      RST = 1'b0;
      check_val("rst_y", bus.paddle_y, 312);
      check_val("rst_moving", bus.moving, 0);
      check_val("rst_done", bus.move_done, 0);
      check_val("rst_top", bus.at_top, 0);
      check_val("rst_bot", bus.at_bottom, 0);

      // Three ups, exact latency
      pulses(3, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check_val("up3_y0", bus.paddle_y, 312);
      check_val("up3_mv0", bus.moving, 1);
      step_clk();
      check_val("up3_y1", bus.paddle_y, 304);
      check_val("up3_mv1", bus.moving, 1);
      step_clk();
      check_val("up3_y2", bus.paddle_y, 296);
      check_val("up3_mv2", bus.moving, 1);
      check_val("up3_dn2", bus.move_done, 0);
      step_clk();
      check_val("up3_y3", bus.paddle_y, 288);
      check_val("up3_mv3", bus.moving, 0);
      check_val("up3_dn3", bus.move_done, 1);
      step_clk();
      check_val("up3_dn4", bus.move_done, 0);
      check_val("up3_y4", bus.paddle_y, 288);

      // Saturation at +15, then clamp at the bottom
      bus.center = 1'b1; step_clk(); bus.center = 1'b0;
      pulses(20, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      wait_done(n);
      check_val("sat_cycles", n, 15);
      check_val("sat_y", bus.paddle_y, 432);
      pulses(15, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      wait_done(n);
      check_val("dn2_y", bus.paddle_y, 552);
      pulses(15, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      wait_done(n);
      check_val("clamp_bot_cycles", n, 10);
      check_val("clamp_bot_y", bus.paddle_y, 624);
      check_val("clamp_bot_flag", bus.at_bottom, 1);
      check_val("clamp_bot_mv", bus.moving, 0);

      // Walk up to 16, then clamp at the top
      for (int f = 0; f < 5; f++) begin
         pulses(15, 1'b1, 1'b0);
         drive(1'b0, 1'b0, 1'b1, 1'b0);
         wait_done(n);
      end
      pulses(1, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      wait_done(n);
      check_val("walk_y", bus.paddle_y, 16);
      pulses(5, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      step_clk();
      check_val("top_y1", bus.paddle_y, 8);
      step_clk();
      check_val("top_y2", bus.paddle_y, 0);
      check_val("top_flag", bus.at_top, 1);
      if (bus.move_done !== 1'b1) wait_done(n);
      check_val("top_y_end", bus.paddle_y, 0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      step_clk();
      check_val("top_discard_mv", bus.moving, 0);
      check_val("top_discard_y", bus.paddle_y, 0);

      // Simultaneous up+down cancels
      pulses(4, 1'b1, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check_val("cancel_mv", bus.moving, 0);
      step_clk();
      check_val("cancel_y", bus.paddle_y, 0);
      check_val("cancel_dn", bus.move_done, 0);

      // Up coincident with tick is kept for the next frame
      pulses(2, 1'b0, 1'b1);
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      wait_done(n);
      check_val("coinc_cycles", n, 2);
      check_val("coinc_y", bus.paddle_y, 16);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      wait_done(n);
      check_val("coinc_next_y", bus.paddle_y, 8);

      // Freeze mid-apply
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check_val("ctr_y", bus.paddle_y, 312);
      pulses(6, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      step_clk();
      step_clk();
      check_val("frz_pre_y", bus.paddle_y, 328);
      bus.freeze = 1'b1;
      step_clk();
      check_val("frz_y", bus.paddle_y, 328);
      check_val("frz_mv", bus.moving, 0);
      check_val("frz_dn", bus.move_done, 0);
      pulses(3, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check_val("frz_hold_y", bus.paddle_y, 328);
      bus.freeze = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check_val("frz_rel_mv", bus.moving, 0);
      step_clk();
      check_val("frz_rel_y", bus.paddle_y, 328);
      check_val("frz_rel_dn", bus.move_done, 0);

      // Center mid-apply
      pulses(5, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      step_clk();
      step_clk();
      check_val("cmid_pre_y", bus.paddle_y, 344);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      check_val("cmid_y", bus.paddle_y, 312);
      check_val("cmid_mv", bus.moving, 0);
      check_val("cmid_dn", bus.move_done, 0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check_val("cmid_pend_mv", bus.moving, 0);

      // Reset mid-apply
      pulses(5, 1'b1, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      step_clk();
      step_clk();
      check_val("rmid_pre_y", bus.paddle_y, 296);
      RST = 1'b1;
      step_clk();
      RST = 1'b0;
      check_val("rmid_y", bus.paddle_y, 312);
      check_val("rmid_mv", bus.moving, 0);
      check_val("rmid_dn", bus.move_done, 0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      check_val("rmid_pend_mv", bus.moving, 0);
      step_clk();
      check_val("rmid_end_y", bus.paddle_y, 312);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
